// File: rtl/imm_ext_unit.sv
// Buffered immediate-extension unit: extends an IN_W-bit immediate to OUT_W bits and
// queues it in a 2-entry output FIFO. Define IMM_EXT_LUI_EN to make mode 3 a load-upper.
module imm_ext_unit #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic             neg;
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_e;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic             push;
    logic             pop;

    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    assign zext = {{(OUT_W-IN_W){1'b0}}, in_imm};

    always_comb begin
        new_e     = '0;
        new_e.neg = in_imm[IN_W-1];
        new_e.tag = in_tag;
        case (in_mode)
            2'd0:    new_e.data = sext;
            2'd1:    new_e.data = zext;
            2'd2:    new_e.data = sext << SHIFT;
`ifdef IMM_EXT_LUI_EN
            default: new_e.data = {in_imm, {(OUT_W-IN_W){1'b0}}};
`else
            default: new_e.data = zext;
`endif
        endcase
    end

    assign in_ready  = (state_q != FULL) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head slot always feeds the outputs; the tail slot only fills when the head is held.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    tail_d  = new_e;
                    state_d = FULL;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_data = out_valid ? head_q.data : '0;
    assign out_tag  = out_valid ? head_q.tag  : '0;
    assign out_neg  = out_valid ? head_q.neg  : 1'b0;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: table of extension vectors plus FIFO stall,
// simultaneous push/pop and mid-operation reset sequences.
module tb_imm_ext_unit;

    localparam int IN_W  = 10;
    localparam int OUT_W = 32;
    localparam int SHIFT = 2;
    localparam int TAG_W = 5;
    localparam int NVEC  = 11;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_neg;

    int errors;
    int checks;

    typedef struct {
        logic [IN_W-1:0]  imm;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] exp_data;
        logic             exp_neg;
    } vec_t;

    vec_t vecs [NVEC];

    imm_ext_unit #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .TAG_W(TAG_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_neg  (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] imm,
                         input logic [1:0] mode, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{10'h1FF, 2'd0, 5'd3,  32'h000001FF, 1'b0};
        vecs[1]  = '{10'h200, 2'd0, 5'd4,  32'hFFFFFE00, 1'b1};
        vecs[2]  = '{10'h200, 2'd1, 5'd5,  32'h00000200, 1'b1};
        vecs[3]  = '{10'h200, 2'd2, 5'd6,  32'hFFFFF800, 1'b1};
        vecs[4]  = '{10'h3FF, 2'd0, 5'd7,  32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{10'h3FF, 2'd2, 5'd8,  32'hFFFFFFFC, 1'b1};
        vecs[6]  = '{10'h1FF, 2'd2, 5'd9,  32'h000007FC, 1'b0};
        vecs[7]  = '{10'h1FF, 2'd1, 5'd10, 32'h000001FF, 1'b0};
        vecs[8]  = '{10'h000, 2'd0, 5'd31, 32'h00000000, 1'b0};
`ifdef IMM_EXT_LUI_EN
        vecs[9]  = '{10'h201, 2'd3, 5'd11, 32'h80400000, 1'b1};
        vecs[10] = '{10'h155, 2'd3, 5'd12, 32'h55400000, 1'b0};
`else
        vecs[9]  = '{10'h201, 2'd3, 5'd11, 32'h00000201, 1'b1};
        vecs[10] = '{10'h155, 2'd3, 5'd12, 32'h00000155, 1'b0};
`endif

        // Reset state, with a request presented during reset
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 10'h123, 2'd0, 5'd1);
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_out_neg",   32'(out_neg),   32'd0);
        drive(1'b0, '0, 2'd0, '0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back vectors with out_ready=1: each appears the cycle after its push
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].tag);
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i),  out_data,       vecs[i].exp_data);
            check($sformatf("vec%0d_tag", i),   32'(out_tag),   32'(vecs[i].tag));
            check($sformatf("vec%0d_neg", i),   32'(out_neg),   32'(vecs[i].exp_neg));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, '0, 2'd0, '0);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  out_data,       32'd0);
        check("drain_tag",   32'(out_tag),   32'd0);

        // Stall: three requests with out_ready=0
        out_ready = 1'b0;
        drive(1'b1, 10'h001, 2'd0, 5'd1);
        step();
        check("stall_a_ready", 32'(in_ready), 32'd1);
        check("stall_a_data",  out_data,      32'h00000001);
        drive(1'b1, 10'h3FE, 2'd0, 5'd2);
        step();
        check("stall_full_ready", 32'(in_ready), 32'd0);
        check("stall_head_tag",   32'(out_tag),  32'd1);
        drive(1'b1, 10'h002, 2'd2, 5'd3);
        step();
        step();
        check("stall_hold_ready", 32'(in_ready),  32'd0);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data",  out_data,       32'h00000001);
        check("stall_hold_tag",   32'(out_tag),   32'd1);
        out_ready = 1'b1;
        step();
        check("drain_b_tag",   32'(out_tag),  32'd2);
        check("drain_b_data",  out_data,      32'hFFFFFFFE);
        check("drain_b_neg",   32'(out_neg),  32'd1);
        check("drain_b_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, '0, 2'd0, '0);
        check("drain_c_tag",  32'(out_tag), 32'd3);
        check("drain_c_data", out_data,     32'h00000008);
        step();
        check("drain_end_valid", 32'(out_valid), 32'd0);

        // Count=1 then simultaneous push and pop: no bubble, count stays 1
        out_ready = 1'b0;
        drive(1'b1, 10'h010, 2'd1, 5'd20);
        step();
        out_ready = 1'b1;
        drive(1'b1, 10'h020, 2'd1, 5'd21);
        step();
        drive(1'b0, '0, 2'd0, '0);
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_tag",   32'(out_tag),   32'd21);
        check("pp_data",  out_data,       32'h00000020);
        check("pp_ready", 32'(in_ready),  32'd1);
        step();
        check("pp_empty", 32'(out_valid), 32'd0);

        // Reset with two entries buffered and a request in flight
        out_ready = 1'b0;
        drive(1'b1, 10'h300, 2'd0, 5'd25);
        step();
        drive(1'b1, 10'h301, 2'd0, 5'd26);
        step();
        check("pre_rst_full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        drive(1'b1, 10'h302, 2'd0, 5'd7);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_data",     out_data,       32'd0);
        check("mid_rst_tag",      32'(out_tag),   32'd0);
        check("mid_rst_in_ready2", 32'(in_ready), 32'd0);
        reset = 1'b0;
        drive(1'b0, '0, 2'd0, '0);
        out_ready = 1'b1;
        #1;
        check("after_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("after_rst_valid%0d", k), 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
